pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 16: number of consecutive EXT_WAIT cycles at which a timeout is reported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 jump_flag_i  in  1  single-cycle pulse from EX: taken branch/jump.
REQ-005 jump_addr_i  in  32  target PC accompanying jump_flag_i.
REQ-006 ex_load_i  in  1  instruction in EX is a load.
REQ-007 ex_rd_i  in  5  destination register of the EX instruction.
REQ-008 id_rs1_i, id_rs2_i  in  5 each  source registers of the ID instruction.
REQ-009 id_rs1_used_i, id_rs2_used_i  in  1 each  source register actually read.
REQ-010 ext_hold_req_i  in  1  multi-cycle resource (memory/bus) busy, freeze the pipeline.
REQ-011 hold_pc_o, hold_if_id_o, hold_id_ex_o  out  1 each  stage freeze (keep contents).
REQ-012 flush_if_id_o, flush_id_ex_o  out  1 each  load INST_NOP/zero into the stage register.
REQ-013 jump_flag_o  out  1 and jump_addr_o  out  32  redirect to the PC register.
REQ-014 ext_timeout_o  out  1  one-cycle pulse on wait timeout.
REQ-015 stall_cnt_o, flush_cnt_o  out  32 each  performance counters.

Function
REQ-016 States SHALL be RUN, LU_STALL, EXT_WAIT, REPLAY.
REQ-017 Load-use hazard = ex_load_i & ex_rd_i!=0 & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
REQ-018 Priority per cycle SHALL be: ext_hold_req_i > jump > load-use.
REQ-019 RUN + jump_flag_i (no ext hold): same cycle jump_flag_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1; state stays RUN; any load-use hazard that cycle is ignored.
REQ-020 RUN + hazard (no jump, no ext hold): same cycle hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1; next state LU_STALL.
REQ-021 LU_STALL: all outputs deasserted; exactly one bubble per hazard; next state RUN (or EXT_WAIT if ext_hold_req_i).
REQ-022 ext_hold_req_i=1 in any state: combinationally hold_pc_o=hold_if_id_o=hold_id_ex_o=1, no flushes, no jump_flag_o; next state EXT_WAIT.
REQ-023 A jump_flag_i pulse coinciding with or arriving during ext hold SHALL be captured (pending flag + 32-bit address); a later pulse while pending is ignored (first wins).
REQ-024 EXT_WAIT with ext_hold_req_i=0: holds drop; next state REPLAY if pending else RUN.
REQ-025 REPLAY: jump_flag_o=1, jump_addr_o=pending address, both flushes=1 for exactly one cycle; pending cleared; next RUN; ext_hold_req_i in REPLAY defers replay (stays pending, to EXT_WAIT).
REQ-026 Wait counter increments each EXT_WAIT cycle, saturates at WAIT_LIMIT; ext_timeout_o pulses once when reaching WAIT_LIMIT; counter cleared on leaving EXT_WAIT.
REQ-027 jump_addr_o SHALL be 0 whenever jump_flag_o=0.

Reset
REQ-028 rst asserted (async): state=RUN, pending cleared, wait counter=0, counters=0; all outputs 0 while rst is high, including mid-stall or mid-replay.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o increments on every cycle with hold_pc_o=1, flush_cnt_o on every cycle with flush_if_id_o=1; both wrap 0xFFFFFFFF->0.
REQ-030 Macro undefined: counter registers not built, stall_cnt_o and flush_cnt_o tied to 0; all other behaviour identical.

Structure
REQ-031 State encodings and WAIT_LIMIT default SHALL live in the shared defines header alongside INST_NOP.
REQ-032 Hazard compare SHALL be a sub-module lu_hazard_det (pure combinational); state/pending registers reuse dff_set.

Verification
REQ-033 ex_load_i=1, ex_rd_i=5, id_rs1_i=5 used -> one cycle hold_pc/hold_if_id/flush_id_ex, next cycle all 0; rd=0 -> no stall.
REQ-034 jump_flag_i pulse, jump_addr_i=0x0000_0100, with simultaneous hazard -> jump_flag_o=1, addr 0x100, both flushes, no hold.
REQ-035 ext_hold_req_i high 3 cycles, jump pulse addr 0x200 in cycle 2 -> 3 hold cycles, then one REPLAY cycle with addr 0x200.
REQ-036 ext_hold_req_i high 20 cycles, WAIT_LIMIT=16 -> single ext_timeout_o pulse on the 16th cycle.
REQ-037 rst pulsed during EXT_WAIT with pending jump -> all outputs 0, no replay after release.
REQ-038 PIPE_CTRL_PERF_EN defined, 3 stall cycles + 1 flush -> stall_cnt_o=3, flush_cnt_o=1; undefined -> both 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared defines for the pipeline controller.
//   INST_NOP       : instruction word the stage registers load on a flush
//   WAIT_LIMIT_DEF : default number of consecutive external-wait cycles before timeout
//   ST_*           : controller state encodings (2-bit, legacy-compatible constants)
package pipe_ctrl_pkg;

  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam int          WAIT_LIMIT_DEF = 16;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_EXT_WAIT = 2'd2;
  localparam logic [1:0] ST_REPLAY   = 2'd3;

  // Per-cycle stage control bundle driven by the controller FSM.
  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/dff_set.sv
// Generic register with asynchronous active-high reset to a supplied value.
//   clk, rst : clock, async reset (active high)
//   set_val  : value loaded while rst is high
//   d, q     : next value / registered value
module dff_set #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] set_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= set_val;
    else     q <= d;
  end

endmodule

// File: rtl/pipe_ctrl_hazard.sv
// lu_hazard_det: purely combinational load-use hazard detector.
//   ex_load, ex_rd        : EX instruction is a load, and its destination
//   id_rs1/2, rs1/2_used  : ID source registers and whether they are read
//   hazard                : ID needs the load result that is not yet available
module lu_hazard_det (
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  output logic       hazard
);

  // x0 is hard-wired zero, so a load into it never creates a dependency.
  assign hazard = ex_load && (ex_rd != 5'd0) &&
                  ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller.
//   Inputs : clk, rst (async, active high), jump_flag_i/jump_addr_i from EX,
//            ex_load_i/ex_rd_i, id_rs1_i/id_rs2_i/id_rs*_used_i for load-use,
//            ext_hold_req_i from a multi-cycle resource.
//   Outputs: hold_pc_o/hold_if_id_o/hold_id_ex_o stage freezes,
//            flush_if_id_o/flush_id_ex_o stage bubbles, jump_flag_o/jump_addr_o
//            PC redirect, ext_timeout_o wait-timeout pulse, stall_cnt_o/flush_cnt_o.
//   Config : define PIPE_CTRL_PERF_EN to build the performance counters;
//            otherwise both counter outputs are tied to zero.
// A jump seen while the pipeline is frozen is parked and replayed once the
// freeze lifts, so the redirect is never lost.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic        ext_hold_req_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        ext_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  logic [1:0]     state, state_nxt;
  logic           pend, pend_nxt;
  logic [31:0]    pend_addr, pend_addr_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           hazard;
  ctrl_t          ctl;
  logic [31:0]    jaddr;

  lu_hazard_det u_haz (
    .ex_load  (ex_load_i),
    .ex_rd    (ex_rd_i),
    .id_rs1   (id_rs1_i),
    .id_rs2   (id_rs2_i),
    .rs1_used (id_rs1_used_i),
    .rs2_used (id_rs2_used_i),
    .hazard   (hazard)
  );

  dff_set #(.W(2))  u_state (.clk(clk), .rst(rst), .set_val(ST_RUN), .d(state_nxt),     .q(state));
  dff_set #(.W(1))  u_pend  (.clk(clk), .rst(rst), .set_val(1'b0),   .d(pend_nxt),      .q(pend));
  dff_set #(.W(32)) u_paddr (.clk(clk), .rst(rst), .set_val(32'd0),  .d(pend_addr_nxt), .q(pend_addr));

  always_comb begin
    ctl           = '0;
    jaddr         = 32'd0;
    state_nxt     = state;
    pend_nxt      = pend;
    pend_addr_nxt = pend_addr;
    if (ext_hold_req_i) begin
      // Freeze wins over everything; a redirect arriving now is parked (first wins).
      ctl.hold_pc    = 1'b1;
      ctl.hold_if_id = 1'b1;
      ctl.hold_id_ex = 1'b1;
      state_nxt      = ST_EXT_WAIT;
      if (jump_flag_i && !pend) begin
        pend_nxt      = 1'b1;
        pend_addr_nxt = jump_addr_i;
      end
    end else begin
      case (state)
        ST_RUN: begin
          if (jump_flag_i) begin
            // Redirect squashes the younger instructions, so any load-use hazard is moot.
            ctl.jump        = 1'b1;
            ctl.flush_if_id = 1'b1;
            ctl.flush_id_ex = 1'b1;
            jaddr           = jump_addr_i;
          end else if (hazard) begin
            ctl.hold_pc     = 1'b1;
            ctl.hold_if_id  = 1'b1;
            ctl.flush_id_ex = 1'b1;
            state_nxt       = ST_LU_STALL;
          end
        end
        ST_LU_STALL: state_nxt = ST_RUN;
        ST_EXT_WAIT: begin
          // Release cycle: a pulse landing exactly here is parked too rather than dropped.
          if (jump_flag_i && !pend) begin
            pend_nxt      = 1'b1;
            pend_addr_nxt = jump_addr_i;
          end
          state_nxt = (pend || jump_flag_i) ? ST_REPLAY : ST_RUN;
        end
        ST_REPLAY: begin
          ctl.jump        = 1'b1;
          ctl.flush_if_id = 1'b1;
          ctl.flush_id_ex = 1'b1;
          jaddr           = pend_addr;
          pend_nxt        = 1'b0;
          state_nxt       = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    // Outputs are forced quiet for the whole reset window, whatever the inputs do.
    if (rst) begin
      ctl   = '0;
      jaddr = 32'd0;
    end
  end

  // Counts consecutive hold cycles; clears as soon as the hold lifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wait_cnt <= '0;
    else if (!ext_hold_req_i) wait_cnt <= '0;
    else if (wait_cnt < WCW'(WAIT_LIMIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires in the WAIT_LIMIT-th hold cycle; saturation keeps it a single pulse.
  assign ext_timeout_o = !rst && ext_hold_req_i && (wait_cnt == WCW'(WAIT_LIMIT - 1));

  assign hold_pc_o     = ctl.hold_pc;
  assign hold_if_id_o  = ctl.hold_if_id;
  assign hold_id_ex_o  = ctl.hold_id_ex;
  assign flush_if_id_o = ctl.flush_if_id;
  assign flush_id_ex_o = ctl.flush_id_ex;
  assign jump_flag_o   = ctl.jump;
  assign jump_addr_o   = jaddr;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (ctl.hold_pc)     stall_cnt <= stall_cnt + 32'd1;
      if (ctl.flush_if_id) flush_cnt <= flush_cnt + 32'd1;
    end
  end
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  typedef struct packed {
    logic        rst, eh, jf;
    logic [31:0] ja;
    logic        ld;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        ex_load_i = 1'b0;
  logic [4:0]  ex_rd_i = 5'd0, id_rs1_i = 5'd0, id_rs2_i = 5'd0;
  logic        id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
  logic        ext_hold_req_i = 1'b0;
  logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o;
  logic        jump_flag_o, ext_timeout_o;
  logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;

  int vecs = 0;
  int errs = 0;
  logic [38:0] exp_q[$];
  logic [38:0] obs;

  always #5 clk = ~clk;

  pipe_ctrl #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ext_hold_req_i(ext_hold_req_i),
    .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .ext_timeout_o(ext_timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump, timeout, addr}
  assign obs = {hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o,
                jump_flag_o, ext_timeout_o, jump_addr_o};

  function automatic logic [38:0] xp(logic [2:0] h, logic [1:0] f, logic j, logic t, logic [31:0] a);
    return {h, f, j, t, a};
  endfunction

  function automatic stim_t st(logic r, logic eh, logic jf, logic [31:0] ja, logic ld,
                               logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2);
    stim_t s;
    s = '{rst:r, eh:eh, jf:jf, ja:ja, ld:ld, rd:rd, rs1:rs1, rs2:rs2, u1:u1, u2:u2};
    return s;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue the expected outputs.
  task automatic apply(input stim_t s, input logic [38:0] e);
    @(posedge clk); #1;
    rst = s.rst; ext_hold_req_i = s.eh; jump_flag_i = s.jf; jump_addr_i = s.ja;
    ex_load_i = s.ld; ex_rd_i = s.rd; id_rs1_i = s.rs1; id_rs2_i = s.rs2;
    id_rs1_used_i = s.u1; id_rs2_used_i = s.u2;
    exp_q.push_back(e);
  endtask

  localparam logic [38:0] IDLE = 39'd0;
  localparam logic [38:0] HOLD = {3'b111, 36'd0};
  localparam logic [38:0] LUS  = {3'b110, 2'b01, 34'd0};

  task automatic test_reset;
    logic [38:0] e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: apply(st(1, 0, 1, 32'h0000_0400, 1, 5, 5, 0, 1, 0), IDLE);
        1: apply(st(1, 1, 1, 32'h0000_0800, 1, 5, 5, 0, 1, 0), IDLE);
        default: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
      endcase
      @(negedge clk);
      vecs++; e = exp_q.pop_front();
      if (obs !== e) begin errs++; $display("FAIL reset[%0d] got %h exp %h", i, obs, e); end
    end
    vecs++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      errs++; $display("FAIL reset_cnt got %h/%h exp 0/0", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_load_use;
    logic [38:0] e;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: apply(st(0, 0, 0, 0, 1, 5, 5, 0, 1, 0), LUS);    // rs1 match
        1: apply(st(0, 0, 0, 0, 1, 5, 5, 0, 1, 0), IDLE);   // single bubble only
        2: apply(st(0, 0, 0, 0, 0, 5, 5, 0, 1, 0), IDLE);   // not a load
        3: apply(st(0, 0, 0, 0, 1, 0, 0, 0, 1, 1), IDLE);   // rd = x0
        4: apply(st(0, 0, 0, 0, 1, 7, 7, 9, 0, 1), IDLE);   // rs1 match but unused
        5: apply(st(0, 0, 0, 0, 1, 7, 3, 7, 0, 1), LUS);    // rs2 match
        6: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        7: apply(st(0, 0, 0, 0, 1, 9, 9, 0, 1, 0), LUS);
        default: apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE); // reset mid-stall
      endcase
      @(negedge clk);
      vecs++; e = exp_q.pop_front();
      if (obs !== e) begin errs++; $display("FAIL load_use[%0d] got %h exp %h", i, obs, e); end
    end
  endtask

  task automatic test_jump;
    logic [38:0] e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        1: apply(st(0, 0, 1, 32'h0000_0100, 1, 5, 5, 0, 1, 0), xp(3'b000, 2'b11, 1, 0, 32'h100));
        2: apply(st(0, 0, 0, 32'h0000_0100, 0, 0, 0, 0, 0, 0), IDLE); // addr zero without jump
        default: apply(st(0, 0, 1, 32'hDEAD_BEE0, 0, 0, 0, 0, 0, 0), xp(3'b000, 2'b11, 1, 0, 32'hDEAD_BEE0));
      endcase
      @(negedge clk);
      vecs++; e = exp_q.pop_front();
      if (obs !== e) begin errs++; $display("FAIL jump[%0d] got %h exp %h", i, obs, e); end
    end
  endtask

  task automatic test_ext_replay;
    logic [38:0] e;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:  apply(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), HOLD);
        1:  apply(st(0, 1, 1, 32'h0000_0200, 1, 5, 5, 0, 1, 0), HOLD);
        2:  apply(st(0, 1, 1, 32'h0000_0300, 0, 0, 0, 0, 0, 0), HOLD); // later pulse ignored
        3:  apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        4:  apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), xp(3'b000, 2'b11, 1, 0, 32'h200));
        5:  apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        // replay deferred by a new hold
        6:  apply(st(0, 1, 1, 32'h0000_0400, 0, 0, 0, 0, 0, 0), HOLD);
        7:  apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        8:  apply(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), HOLD);
        9:  apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        10: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), xp(3'b000, 2'b11, 1, 0, 32'h400));
        default: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
      endcase
      @(negedge clk);
      vecs++; e = exp_q.pop_front();
      if (obs !== e) begin errs++; $display("FAIL ext_replay[%0d] got %h exp %h", i, obs, e); end
    end
  endtask

  task automatic test_timeout;
    logic [38:0] e;
    // 20-cycle hold, 2 release cycles, then a 3-cycle hold to show the counter restarted.
    for (int i = 0; i < 25; i++) begin
      if (i < 20)      apply(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), (i == 15) ? (HOLD | {6'd0, 1'b1, 32'd0}) : HOLD);
      else if (i < 22) apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
      else             apply(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), HOLD);
      @(negedge clk);
      vecs++; e = exp_q.pop_front();
      if (obs !== e) begin errs++; $display("FAIL timeout[%0d] got %h exp %h", i, obs, e); end
    end
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
    @(negedge clk); void'(exp_q.pop_front());
  endtask

  task automatic test_reset_pending;
    logic [38:0] e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: apply(st(0, 1, 1, 32'h0000_0500, 0, 0, 0, 0, 0, 0), HOLD);
        1: apply(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), HOLD);
        2: apply(st(1, 1, 1, 32'h0000_0600, 1, 5, 5, 0, 1, 0), IDLE);
        3: apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        default: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE); // no replay after release
      endcase
      @(negedge clk);
      vecs++; e = exp_q.pop_front();
      if (obs !== e) begin errs++; $display("FAIL rst_pending[%0d] got %h exp %h", i, obs, e); end
    end
  endtask

  task automatic test_perf;
    logic [38:0] e;
    logic [31:0] exp_s, exp_f;
`ifdef PIPE_CTRL_PERF_EN
    exp_s = 32'd3; exp_f = 32'd1;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        1: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        2, 3, 4: apply(st(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), HOLD);
        5: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
        6: apply(st(0, 0, 1, 32'h0000_0700, 0, 0, 0, 0, 0, 0), xp(3'b000, 2'b11, 1, 0, 32'h700));
        default: apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), IDLE);
      endcase
      @(negedge clk);
      vecs++; e = exp_q.pop_front();
      if (obs !== e) begin errs++; $display("FAIL perf_seq[%0d] got %h exp %h", i, obs, e); end
    end
    vecs++;
    if (stall_cnt_o !== exp_s) begin errs++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt_o, exp_s); end
    vecs++;
    if (flush_cnt_o !== exp_f) begin errs++; $display("FAIL flush_cnt got %0d exp %0d", flush_cnt_o, exp_f); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_ext_replay();
    test_timeout();
    test_reset_pending();
    test_perf();
    if (exp_q.size() != 0) begin
      errs++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1);
  end

endmodule
